pwm_meas: RTL and testbench

//   PWM capture/decoder: the receive side of the motor-control PWM link. Samples an

---
 rtl/pwm_pkg.sv | 15 +
 rtl/sync_edge.sv | 37 +++
 rtl/pwm_meas.sv | 124 ++++++++++++
 tb/tb_pwm_meas.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM link: default sizing and the decoder FSM state encoding.
package pwm_pkg;

  localparam int PWM_CNT_W    = 10;
  localparam int PWM_PERIOD   = 2 ** PWM_CNT_W;
  localparam int PWM_SYNC_STG = 2;
  localparam int PWM_TIMEOUT  = 4096;

  typedef enum logic [1:0] {
    WAIT_RISE = 2'd0,
    MEAS_HI   = 2'd1,
    MEAS_LO   = 2'd2
  } pwm_state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous level, followed by one edge-detect flop.
module sync_edge #(
  parameter int SYNC_STG = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic [SYNC_STG-1:0] sync_reg;
  logic                prev_reg;
  logic [SYNC_STG:0]   fill_reg;
  logic                armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
      fill_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STG-2:0], din};
      prev_reg <= sync_reg[SYNC_STG-1];
      fill_reg <= {fill_reg[SYNC_STG-1:0], 1'b1};
    end
  end

  // Edges are only trusted once the whole chain holds real samples, so a line
  // that is already high when reset releases does not look like a rising edge.
  assign armed = &fill_reg;
  assign lvl   = sync_reg[SYNC_STG-1];
  assign rise  = armed & lvl & ~prev_reg;
  assign fall  = armed & ~lvl & prev_reg;

endmodule

// File: rtl/pwm_meas.sv
// PWM capture/decoder: measures high time and rise-to-rise period of a synchronized PWM
// input and reports the duty code, period, framing error and loss of signal.
module pwm_meas
  import pwm_pkg::*;
#(
  parameter int CNT_W    = PWM_CNT_W,
  parameter int SYNC_STG = PWM_SYNC_STG,
  parameter int TIMEOUT  = PWM_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] duty,
  output logic [CNT_W:0]   period,
  output logic             duty_vld,
  output logic             period_err,
  output logic             sig_lost
);

  localparam int                PERIOD   = 2 ** CNT_W;
  localparam int                TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W:0]    PERIOD_C = (CNT_W + 1)'(PERIOD);
  localparam logic [TMO_W-1:0]  TMO_C    = TMO_W'(TIMEOUT);

  logic lvl, rise, fall;

  sync_edge #(.SYNC_STG(SYNC_STG)) u_sync_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (pwm_in),
    .lvl  (lvl),
    .rise (rise),
    .fall (fall)
  );

  pwm_state_t       state_reg;
  logic [CNT_W:0]   hi_cnt_reg, per_cnt_reg;
  logic [TMO_W-1:0] tmo_cnt_reg;
  logic [CNT_W-1:0] duty_reg;
  logic [CNT_W:0]   period_reg;
  logic             duty_vld_reg, period_err_reg, sig_lost_reg;

  logic [CNT_W:0]   hi_inc, per_inc, hi_m1;
  logic [TMO_W-1:0] tmo_inc;
  logic [CNT_W-1:0] duty_sat;

  assign hi_inc   = (&hi_cnt_reg)  ? hi_cnt_reg  : hi_cnt_reg + 1'b1;
  assign per_inc  = (&per_cnt_reg) ? per_cnt_reg : per_cnt_reg + 1'b1;
  assign tmo_inc  = (&tmo_cnt_reg) ? tmo_cnt_reg : tmo_cnt_reg + 1'b1;
  assign hi_m1    = hi_cnt_reg - 1'b1;
  assign duty_sat = hi_m1[CNT_W] ? '1 : hi_m1[CNT_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= WAIT_RISE;
      hi_cnt_reg     <= '0;
      per_cnt_reg    <= '0;
      tmo_cnt_reg    <= '0;
      duty_reg       <= '0;
      period_reg     <= '0;
      duty_vld_reg   <= 1'b0;
      period_err_reg <= 1'b0;
      sig_lost_reg   <= 1'b0;
    end else begin
      duty_vld_reg <= 1'b0;
      per_cnt_reg  <= per_inc;
      tmo_cnt_reg  <= tmo_inc;
      case (state_reg)
        WAIT_RISE: begin
          if (rise) begin
            hi_cnt_reg  <= 1;
            per_cnt_reg <= 1;
            state_reg   <= MEAS_HI;
          end
        end
        MEAS_HI: begin
          if (fall) begin
            state_reg <= MEAS_LO;
          end else if (hi_cnt_reg == PERIOD_C && lvl) begin
            // A full frame of high acts as a frame boundary, including for the timeout.
            duty_reg       <= '1;
            period_reg     <= PERIOD_C;
            period_err_reg <= 1'b0;
            duty_vld_reg   <= 1'b1;
            hi_cnt_reg     <= 1;
            per_cnt_reg    <= 1;
            tmo_cnt_reg    <= 1;
          end else begin
            hi_cnt_reg <= hi_inc;
          end
        end
        MEAS_LO: begin
          if (rise) begin
            duty_reg       <= duty_sat;
            period_reg     <= per_cnt_reg;
            period_err_reg <= (per_cnt_reg != PERIOD_C);
            duty_vld_reg   <= 1'b1;
            hi_cnt_reg     <= 1;
            per_cnt_reg    <= 1;
            state_reg      <= MEAS_HI;
          end
        end
        default: state_reg <= WAIT_RISE;
      endcase
      // A rise in the same cycle as the timeout wins and keeps the link alive.
      if (rise) begin
        tmo_cnt_reg  <= 1;
        sig_lost_reg <= 1'b0;
      end else if (tmo_cnt_reg >= TMO_C) begin
        sig_lost_reg <= 1'b1;
        duty_reg     <= '0;
        duty_vld_reg <= 1'b0;
        state_reg    <= WAIT_RISE;
      end
    end
  end

  assign duty       = duty_reg;
  assign period     = period_reg;
  assign duty_vld   = duty_vld_reg;
  assign period_err = period_err_reg;
  assign sig_lost   = sig_lost_reg;

endmodule

// File: tb/tb_pwm_meas.sv
// Self-checking bench for pwm_meas: frame-level reference model compared every cycle,
// plus literal expectations for the directed scenarios and a jittered random run.
module tb_pwm_meas;

  localparam int PERIOD  = 1024;
  localparam int TIMEOUT = 4096;
  localparam int LAT     = 2;  // edges between an input sample and the edge whose compare sees it

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pwm_in = 1'b0;
  logic [9:0]  duty;
  logic [10:0] period;
  logic        duty_vld, period_err, sig_lost;

  pwm_meas #(.CNT_W(10), .SYNC_STG(2), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pwm_in    (pwm_in),
    .duty      (duty),
    .period    (period),
    .duty_vld  (duty_vld),
    .period_err(period_err),
    .sig_lost  (sig_lost)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic check_range(input string name, input int got, input int lo, input int hi);
    n_checks++;
    if (got >= lo && got <= hi) n_pass++;
    else $display("FAIL %s: got %0d required %0d..%0d", name, got, lo, hi);
  endtask

  // Reference model: works on the sampled input stream in terms of edge indices and
  // frame timestamps (last rise, first fall, last frame boundary).
  int ec = 0, rise_e = 0, fall_e = 0, bound_e = 0;
  bit measuring = 0, have_fall = 0;
  bit h0 = 0, h1 = 0, h2 = 0, h3 = 0;
  int exp_duty = 0, exp_period = 0;
  bit exp_vld = 0, exp_err = 0, exp_lost = 0;

  initial begin : model
    bit r, f;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        ec = 0; rise_e = 0; fall_e = 0; bound_e = 0;
        measuring = 0; have_fall = 0;
        h0 = 0; h1 = 0; h2 = 0; h3 = 0;
        exp_duty = 0; exp_period = 0; exp_vld = 0; exp_err = 0; exp_lost = 0;
      end else begin
        h3 = h2; h2 = h1; h1 = h0; h0 = pwm_in;
        r = (ec > LAT) && h2 && !h3;
        f = (ec > LAT) && !h2 && h3;
        exp_vld = 0;
        if (r) begin
          if (measuring && have_fall) begin
            exp_duty   = ((fall_e - rise_e) > PERIOD ? PERIOD : (fall_e - rise_e)) - 1;
            exp_period = (ec - rise_e) > 2047 ? 2047 : (ec - rise_e);
            exp_err    = (exp_period != PERIOD);
            exp_vld    = 1;
          end
          measuring = 1; have_fall = 0; rise_e = ec; bound_e = ec; exp_lost = 0;
        end else if (measuring && !have_fall) begin
          if (f) begin
            have_fall = 1; fall_e = ec;
          end else if (ec - rise_e == PERIOD) begin
            exp_duty = PERIOD - 1; exp_period = PERIOD; exp_err = 0; exp_vld = 1;
            rise_e = ec; bound_e = ec;
          end
        end
        if (!r && (ec - bound_e) >= TIMEOUT) begin
          exp_lost = 1; exp_duty = 0; exp_vld = 0; measuring = 0;
        end
        ec++;
      end
    end
  end

  initial begin : compare
    logic [23:0] got_v, exp_v;
    forever begin
      @(negedge clk);
      got_v = {duty, period, duty_vld, period_err, sig_lost};
      exp_v = {10'(exp_duty), 11'(exp_period), exp_vld, exp_err, exp_lost};
      check("cycle_outputs", got_v, exp_v);
    end
  end

  // Record the most recent decoded frame for the directed literal checks.
  int cyc = 0, last_vld_cyc = 0, vld_gap = 0, vld_cnt = 0;
  int last_duty = 0, last_period = 0;
  bit last_err = 0, collect = 0;
  int dec_duty[$], dec_period[$];

  initial begin : capture
    forever begin
      @(negedge clk);
      cyc++;
      if (duty_vld) begin
        last_duty = duty; last_period = period; last_err = period_err;
        vld_gap = cyc - last_vld_cyc; last_vld_cyc = cyc; vld_cnt++;
        if (collect) begin
          dec_duty.push_back(int'(duty));
          dec_period.push_back(int'(period));
        end
      end
    end
  end

  task automatic hold(input bit v, input int n);
    @(negedge clk);
    pwm_in = v;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic frame(input int hi, input int lo);
    hold(1'b1, hi);
    hold(1'b0, lo);
  endtask

  // Edge lands either just before or just after the next sampling edge.
  task automatic jhold(input bit v, input int n);
    @(negedge clk);
    if ($urandom_range(1) == 1) #($urandom_range(6, 9));
    else #($urandom_range(1, 4));
    pwm_in = v;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #3 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  int drv_d[$];

  initial begin : stim
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    check("reset_duty", duty, 0);
    check("reset_period", period, 0);
    check("reset_vld", duty_vld, 0);
    check("reset_err", period_err, 0);
    check("reset_lost", sig_lost, 0);

    // 257 high / 767 low frames
    vld_cnt = 0;
    hold(1'b0, 20);
    repeat (4) frame(257, 767);
    hold(1'b1, 10);
    $display("t1 frames 257/767: duty=%0d period=%0d err=%0b vlds=%0d gap=%0d", last_duty, last_period, last_err, vld_cnt, vld_gap);
    check("t1_duty", last_duty, 256);
    check("t1_period", last_period, 1024);
    check("t1_err", last_err, 0);
    check("t1_vld_count", vld_cnt, 4);
    check("t1_gap", vld_gap, 1024);

    // constant high
    vld_cnt = 0;
    hold(1'b1, 3 * PERIOD + 100);
    $display("t2 constant high: duty=%0d period=%0d vlds=%0d gap=%0d", last_duty, last_period, vld_cnt, vld_gap);
    check("t2_duty", last_duty, 1023);
    check("t2_period", last_period, 1024);
    check("t2_vld_count", vld_cnt, 3);
    check("t2_gap", vld_gap, 1024);

    // minimum duty, then an over-long frame
    hold(1'b0, 50);
    repeat (3) frame(1, 1023);
    hold(1'b1, 10);
    $display("t3a high1/low1023: duty=%0d period=%0d err=%0b", last_duty, last_period, last_err);
    check("t3_duty_min", last_duty, 0);
    check("t3_period_min", last_period, 1024);
    hold(1'b1, 1014);
    hold(1'b0, 1);
    hold(1'b1, 10);
    $display("t3b high1024/low1: duty=%0d period=%0d err=%0b", last_duty, last_period, last_err);
    check("t3_period_long", last_period, 1025);
    check("t3_err_long", last_err, 1);
    check("t3_duty_sat", last_duty, 1023);

    // loss of signal and recovery
    hold(1'b0, 1000);
    repeat (2) frame(257, 767);
    hold(1'b1, 257);
    vld_cnt = 0;
    hold(1'b0, 4200);
    $display("t4 held low: sig_lost=%0b duty=%0d vlds=%0d", sig_lost, duty, vld_cnt);
    check("t4_lost", sig_lost, 1);
    check("t4_duty_zero", duty, 0);
    check("t4_no_vld", vld_cnt, 0);
    frame(257, 767);
    frame(257, 767);
    hold(1'b1, 10);
    $display("t4 recovered: sig_lost=%0b duty=%0d period=%0d vlds=%0d", sig_lost, last_duty, last_period, vld_cnt);
    check("t4_lost_clear", sig_lost, 0);
    check("t4_recover_duty", last_duty, 256);
    check("t4_recover_period", last_period, 1024);
    check("t4_recover_vlds", vld_cnt, 2);

    // reset in the middle of a high phase
    hold(1'b1, 50);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    $display("t5 mid-frame reset: duty=%0d period=%0d vld=%0b err=%0b lost=%0b", duty, period, duty_vld, period_err, sig_lost);
    check("t5_rst_duty", duty, 0);
    check("t5_rst_period", period, 0);
    check("t5_rst_err", period_err, 0);
    check("t5_rst_lost", sig_lost, 0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    vld_cnt = 0;
    hold(1'b1, 100);
    hold(1'b0, 900);
    frame(257, 767);
    hold(1'b1, 10);
    $display("t5 after release: vlds=%0d duty=%0d period=%0d", vld_cnt, last_duty, last_period);
    check("t5_first_vlds", vld_cnt, 1);
    check("t5_first_duty", last_duty, 256);
    check("t5_first_period", last_period, 1024);

    // random duty codes with sub-clock jitter on every edge
    do_reset();
    dec_duty.delete();
    dec_period.delete();
    collect = 1;
    hold(1'b0, 20);
    for (int i = 0; i < 12; i++) begin
      int d;
      d = $urandom_range(1, 1021);
      drv_d.push_back(d);
      jhold(1'b1, d + 1);
      jhold(1'b0, PERIOD - d - 1);
    end
    jhold(1'b1, 10);
    hold(1'b1, 5);
    collect = 0;
    check("t6_frame_count", dec_duty.size(), drv_d.size());
    for (int i = 0; i < drv_d.size() && i < dec_duty.size(); i++) begin
      $display("t6 frame %0d: driven=%0d decoded=%0d period=%0d", i, drv_d[i], dec_duty[i], dec_period[i]);
      check_range($sformatf("t6_duty[%0d]", i), dec_duty[i], drv_d[i] - 1, drv_d[i] + 1);
      check_range($sformatf("t6_period[%0d]", i), dec_period[i], 1023, 1025);
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
